cpu_controller: RTL and testbench

Instruction register, decoder and control FSM that sits directly upstream of `datapath` and sequences it. It latches a 16-bit instruction, decodes register numbers, shift code, ALU operation and immediates, then steps through the read, ALU and write-back cycles. It drives every `datapath` control input and signals completion on `w`.

---
 rtl/cpu_controller_if.sv | 42 ++++
 rtl/cpu_controller.sv | 160 ++++++++++++++++
 tb/tb_cpu_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_controller_if
//  Description : Instruction input and datapath control bundle between
//                cpu_controller (master) and the datapath / host (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_controller_if;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    modport master (
        input  s, load, in,
        output w, readnum, writenum, write, vsel,
        output loada, loadb, loadc, loads, asel, bsel,
        output shift, ALUop, sximm8, sximm5
    );

    modport slave (
        output s, load, in,
        input  w, readnum, writenum, write, vsel,
        input  loada, loadb, loadc, loads, asel, bsel,
        input  shift, ALUop, sximm8, sximm5
    );
endinterface
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_controller
//  Description : Instruction register, decoder and control FSM sequencing the
//                datapath. Optional macro CTRL_STATUS_ALL_EN makes every
//                instruction passing through ALU update status.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_controller (
    input  wire              clk,
    input  wire              reset,
    cpu_controller_if.master bus
);
    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_GET_A     = 3'd2,
        ST_GET_B     = 3'd3,
        ST_ALU       = 3'd4,
        ST_WRITE_REG = 3'd5,
        ST_WRITE_IMM = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;

    // Instruction fields
    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [2:0] w_rm;
    logic       w_is_mov_imm;
    logic       w_is_mov_reg;
    logic       w_is_alu;
    logic       w_is_cmp;
    logic       w_is_mvn;
    logic       w_loads_alu;

    assign w_opcode     = r_ir[15:13];
    assign w_op         = r_ir[12:11];
    assign w_rn         = r_ir[10:8];
    assign w_rd         = r_ir[7:5];
    assign w_rm         = r_ir[2:0];
    assign w_is_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_is_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_is_alu     = (w_opcode == 3'b101);
    assign w_is_cmp     = w_is_alu && (w_op == 2'b01);
    assign w_is_mvn     = w_is_alu && (w_op == 2'b11);

`ifdef CTRL_STATUS_ALL_EN
    assign w_loads_alu  = 1'b1;
`else
    assign w_loads_alu  = w_is_cmp;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_WAIT;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_WAIT) && bus.load)
                r_ir <= bus.in;
        end
    end

    logic [2:0] w_readnum;
    logic [2:0] w_writenum;
    logic       w_write;
    logic [1:0] w_vsel;
    logic       w_loada;
    logic       w_loadb;
    logic       w_loadc;
    logic       w_loads;
    logic       w_asel;
    logic [1:0] w_aluop;

    always_comb begin
        w_next     = r_state;
        w_readnum  = 3'b000;
        w_writenum = 3'b000;
        w_write    = 1'b0;
        w_vsel     = 2'b00;
        w_loada    = 1'b0;
        w_loadb    = 1'b0;
        w_loadc    = 1'b0;
        w_loads    = 1'b0;
        w_asel     = 1'b0;
        w_aluop    = 2'b00;
        unique case (r_state)
            ST_WAIT: begin
                if (bus.s)
                    w_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_is_mov_imm)
                    w_next = ST_WRITE_IMM;
                else if (w_is_mov_reg || w_is_mvn)
                    w_next = ST_GET_B;
                else if (w_is_alu)
                    w_next = ST_GET_A;
                else
                    w_next = ST_WAIT;
            end
            ST_GET_A: begin
                w_readnum = w_rn;
                w_loada   = 1'b1;
                w_next    = ST_GET_B;
            end
            ST_GET_B: begin
                w_readnum = w_rm;
                w_loadb   = 1'b1;
                w_next    = ST_ALU;
            end
            ST_ALU: begin
                w_loadc = 1'b1;
                w_loads = w_loads_alu;
                w_aluop = w_is_alu ? w_op : 2'b00;
                // MOV reg and MVN have no Rn operand, so A is forced to zero
                w_asel  = w_is_mov_reg || w_is_mvn;
                w_next  = w_is_cmp ? ST_WAIT : ST_WRITE_REG;
            end
            ST_WRITE_REG: begin
                w_writenum = w_rd;
                w_vsel     = 2'b00;
                w_write    = 1'b1;
                w_next     = ST_WAIT;
            end
            ST_WRITE_IMM: begin
                w_writenum = w_rn;
                w_vsel     = 2'b10;
                w_write    = 1'b1;
                w_next     = ST_WAIT;
            end
            default: begin
                w_next = ST_WAIT;
            end
        endcase
    end

    assign bus.w        = (r_state == ST_WAIT);
    assign bus.readnum  = w_readnum;
    assign bus.writenum = w_writenum;
    assign bus.write    = w_write;
    assign bus.vsel     = w_vsel;
    assign bus.loada    = w_loada;
    assign bus.loadb    = w_loadb;
    assign bus.loadc    = w_loadc;
    assign bus.loads    = w_loads;
    assign bus.asel     = w_asel;
    assign bus.bsel     = 1'b0;
    assign bus.shift    = r_ir[4:3];
    assign bus.ALUop    = w_aluop;
    assign bus.sximm8   = {{8{r_ir[7]}}, r_ir[7:0]};
    assign bus.sximm5   = {{11{r_ir[4]}}, r_ir[4:0]};

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_controller
//  Description : Directed bench for cpu_controller driving a behavioural
//                datapath (register file, shifter, ALU, status).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;
    logic clk;
    logic reset;
    logic dp_init;

    cpu_controller_if bus ();

    cpu_controller u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath: status = {V, N, Z}
    logic [15:0] rf [8];
    logic [15:0] r_a, r_b, r_c;
    logic [2:0]  status;
    logic [15:0] w_sh, w_ain, w_bin, w_alu;
    logic        w_v;

    always_comb begin
        case (bus.shift)
            2'b01:   w_sh = {r_b[14:0], 1'b0};
            2'b10:   w_sh = {1'b0, r_b[15:1]};
            2'b11:   w_sh = {r_b[15], r_b[15:1]};
            default: w_sh = r_b;
        endcase
        w_ain = bus.asel ? 16'h0000 : r_a;
        w_bin = bus.bsel ? bus.sximm5 : w_sh;
        w_v   = 1'b0;
        case (bus.ALUop)
            2'b00: begin
                w_alu = w_ain + w_bin;
                w_v   = (w_ain[15] == w_bin[15]) && (w_alu[15] != w_ain[15]);
            end
            2'b01: begin
                w_alu = w_ain - w_bin;
                w_v   = (w_ain[15] != w_bin[15]) && (w_alu[15] != w_ain[15]);
            end
            2'b10:   w_alu = w_ain & w_bin;
            default: w_alu = ~w_bin;
        endcase
    end

    always @(posedge clk) begin
        if (dp_init) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
            r_a    <= 16'h0000;
            r_b    <= 16'h0000;
            r_c    <= 16'h0000;
            status <= 3'b000;
        end else begin
            if (bus.write) begin
                case (bus.vsel)
                    2'b00:   rf[bus.writenum] <= r_c;
                    2'b10:   rf[bus.writenum] <= bus.sximm8;
                    default: rf[bus.writenum] <= 16'h0000;
                endcase
            end
            if (bus.loada) r_a <= rf[bus.readnum];
            if (bus.loadb) r_b <= rf[bus.readnum];
            if (bus.loadc) r_c <= w_alu;
            if (bus.loads) status <= {w_v, w_alu[15], (w_alu == 16'h0000)};
        end
    end

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    int       edges;
    int       busy;
    bit       saw_write;
    bit [2:0] ra, rb;

    // Load and start together, then count edges until w returns
    task automatic run_instr(input logic [15:0] word);
        @(negedge clk);
        bus.in   = word;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        @(posedge clk);
        #1;
        bus.load  = 1'b0;
        bus.s     = 1'b0;
        edges     = 1;
        busy      = 0;
        saw_write = 1'b0;
        ra        = 3'b111;
        rb        = 3'b111;
        while (bus.w == 1'b0 && edges < 20) begin
            busy++;
            if (bus.write) saw_write = 1'b1;
            if (bus.loada) ra = bus.readnum;
            if (bus.loadb) rb = bus.readnum;
            @(posedge clk);
            #1;
            edges++;
        end
        if (edges >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: w did not return for %h", word);
        end
    endtask

    logic [2:0] status_before;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        dp_init  = 1'b1;
        bus.s    = 1'b0;
        bus.load = 1'b0;
        bus.in   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_w",      16'(bus.w),      16'h0001);
        check("rst_write",  16'(bus.write),  16'h0000);
        check("rst_loads",  16'({bus.loada, bus.loadb, bus.loadc, bus.loads}), 16'h0000);
        check("rst_sximm8", bus.sximm8, 16'h0000);
        check("rst_sximm5", bus.sximm5, 16'h0000);
        @(negedge clk);
        reset   = 1'b0;
        dp_init = 1'b0;

        run_instr(16'hD007);
        check("movimm0_edges", 16'(edges), 16'd3);
        check("movimm0_busy",  16'(busy),  16'd2);
        run_instr(16'hD102);
        check("movimm1_edges", 16'(edges), 16'd3);
        check("r0", rf[0], 16'h0007);
        check("r1", rf[1], 16'h0002);

        run_instr(16'hA148);
        check("add_edges",   16'(edges), 16'd6);
        check("add_r2",      rf[2], 16'h0010);
        check("add_readn_a", 16'(ra), 16'h0001);
        check("add_readn_b", 16'(rb), 16'h0000);

        run_instr(16'hD342);
        check("r3", rf[3], 16'h0042);
        run_instr(16'hAB03);
        check("cmp_edges",  16'(edges), 16'd5);
        check("cmp_status", 16'(status), 16'h0001);
        check("cmp_nowrite", 16'(saw_write), 16'h0000);

        run_instr(16'hB880);
        check("mvn_edges", 16'(edges), 16'd5);
        check("mvn_r4",    rf[4], 16'hFFF8);
        run_instr(16'hD5FF);
        check("mov_r5",    rf[5], 16'hFFFF);
        check("sximm8_ff", bus.sximm8, 16'hFFFF);
        check("sximm5_ff", bus.sximm5, 16'hFFFF);

        run_instr(16'hC0E9);
        check("movreg_edges", 16'(edges), 16'd5);
        check("movreg_r7",    rf[7], 16'h0004);

        status_before = status;
        run_instr(16'h0000);
        check("ill_edges",  16'(edges), 16'd2);
        check("ill_write",  16'(saw_write), 16'h0000);
        check("ill_status", 16'(status), 16'(status_before));
        check("ill_r2",     rf[2], 16'h0010);

        // Reset during ADD R2,R1,R0 with a busy-time load attempt
        @(negedge clk);
        bus.in   = 16'hA140;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        @(posedge clk);
        #1;
        check("rst_geta_loada", 16'(bus.loada), 16'h0001);
        bus.in   = 16'hD0FF;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        check("rst_getb_loadb", 16'(bus.loadb), 16'h0001);
        check("busy_load_ign",  bus.sximm8, 16'h0040);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_w",      16'(bus.w),     16'h0001);
        check("midrst_write",  16'(bus.write), 16'h0000);
        check("midrst_sximm8", bus.sximm8, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_idle_w", 16'(bus.w), 16'h0001);
        check("midrst_r2",     rf[2], 16'h0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
